// File: rtl/alb_mss_fab_pkg.sv
// alb_mss_fab_pkg: shared AHB-Lite encodings, default-slave FSM states and clog2 helper
package alb_mss_fab_pkg;
  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_BUSY = 2'b01;
  localparam logic [1:0] HTRANS_NSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ  = 2'b11;
  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;
  typedef enum logic [1:0] {D_IDLE, D_ERR1, D_ERR2} dflt_st_e;
  function automatic int clog2(input int n);
    int r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction
endpackage

// File: rtl/alb_mss_fab_ahbl_dflt_slv.sv
// alb_mss_fab_ahbl_dflt_slv: default slave issuing two-cycle ERROR on unmapped accesses, with error log
// clk, rst_a (async high), bus_clk_en : clocking; all state moves only when bus_clk_en=1
// accept : muxed m_hready (address phase accepted); miss : region not decoded to a slave
// htrans, addr : address-phase HTRANS and {region,addr}
// err_clr : clear of the log; hready/hresp : default-slave response
// err_cnt : saturating error count; err_addr : {region,addr} of last unmapped NSEQ/SEQ
module alb_mss_fab_ahbl_dflt_slv
  import alb_mss_fab_pkg::*;
#(
  parameter int AW        = 36,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_a,
  input  logic                 bus_clk_en,
  input  logic                 accept,
  input  logic                 miss,
  input  logic [1:0]           htrans,
  input  logic [AW-1:0]        addr,
  input  logic                 err_clr,
  output logic                 hready,
  output logic                 hresp,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [AW-1:0]        err_addr
);
  dflt_st_e st, st_nx;
  logic start;
  assign start = accept && miss && !(htrans inside {HTRANS_IDLE, HTRANS_BUSY});
  always_ff @(posedge clk or posedge rst_a)
    if (rst_a) st <= D_IDLE;
    else if (bus_clk_en) st <= st_nx;
  always_comb begin
    st_nx  = (st == D_ERR1) ? D_ERR2 : (start ? D_ERR1 : D_IDLE);
    hready = (st != D_ERR1);
    hresp  = (st == D_IDLE) ? HRESP_OKAY : HRESP_ERROR;
  end
  // clear takes priority over a coincident increment
  always_ff @(posedge clk or posedge rst_a)
    if (rst_a) begin
      err_cnt  <= '0;
      err_addr <= '0;
    end else if (bus_clk_en) begin
      if (err_clr) begin
        err_cnt  <= '0;
        err_addr <= '0;
      end else if (start) begin
        err_cnt  <= (&err_cnt) ? err_cnt : err_cnt + 1'b1;
        err_addr <= addr;
      end
    end
endmodule

// File: rtl/alb_mss_fab_ahbl_rgon_mux.sv
// alb_mss_fab_ahbl_rgon_mux: AHB-Lite region decoder and response mux with built-in default slave
// m_* : master side (address/control/wdata in, hrdata/hresp/hready out)
// s_* : slave side (one-hot hsel and broadcast copies out, per-slave hrdata/hresp/hreadyout in)
// err_cnt/err_addr/err_clr : unmapped-access log and its synchronous clear
module alb_mss_fab_ahbl_rgon_mux
  import alb_mss_fab_pkg::*;
#(
  parameter int             ADDR_W    = 32,
  parameter int             DATA_W    = 64,
  parameter int             RGON_W    = 4,
  parameter int             L_W       = 4,
  parameter logic [L_W-1:0] RGON_EN   = {L_W{1'b1}},
  parameter int             ERR_CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_a,
  input  logic                     bus_clk_en,
  input  logic [1:0]               m_htrans,
  input  logic                     m_hwrite,
  input  logic [ADDR_W-1:0]        m_haddr,
  input  logic [RGON_W-1:0]        m_hregion,
  input  logic [2:0]               m_hsize,
  input  logic [2:0]               m_hburst,
  input  logic [DATA_W-1:0]        m_hwdata,
  output logic [DATA_W-1:0]        m_hrdata,
  output logic                     m_hresp,
  output logic                     m_hready,
  output logic [L_W-1:0]           s_hsel,
  output logic [1:0]               s_htrans,
  output logic                     s_hwrite,
  output logic [ADDR_W-1:0]        s_haddr,
  output logic [2:0]               s_hsize,
  output logic [2:0]               s_hburst,
  output logic [DATA_W-1:0]        s_hwdata,
  output logic                     s_hready,
  input  logic [L_W*DATA_W-1:0]    s_hrdata,
  input  logic [L_W-1:0]           s_hresp,
  input  logic [L_W-1:0]           s_hready_resp,
  output logic [ERR_CNT_W-1:0]     err_cnt,
  output logic [RGON_W+ADDR_W-1:0] err_addr,
  input  logic                     err_clr
);
  localparam int IDX_W = (clog2(L_W) > 0) ? clog2(L_W) : 1;
  logic [IDX_W-1:0]  idx;
  logic              dflt, hit, d_hready, d_hresp, sl_hresp, sl_hready;
  logic [DATA_W-1:0] sl_hrdata;
  // disabled or out-of-range regions never assert a select, so hit is the OR of the selects
  always_comb begin
    s_hsel = '0;
    for (int i = 0; i < L_W; i++) s_hsel[i] = RGON_EN[i] && (m_hregion == RGON_W'(i));
  end
  assign hit      = |s_hsel;
  assign s_htrans = m_htrans;
  assign s_hwrite = m_hwrite;
  assign s_haddr  = m_haddr;
  assign s_hsize  = m_hsize;
  assign s_hburst = m_hburst;
  assign s_hwdata = m_hwdata;
  assign s_hready = m_hready;
  always_ff @(posedge clk or posedge rst_a)
    if (rst_a) begin
      idx  <= '0;
      dflt <= 1'b1;
    end else if (bus_clk_en && m_hready) begin
      idx  <= m_hregion[IDX_W-1:0];
      dflt <= !hit;
    end
  always_comb begin
    sl_hrdata = '0;
    sl_hresp  = HRESP_OKAY;
    sl_hready = 1'b1;
    for (int i = 0; i < L_W; i++)
      if (idx == IDX_W'(i)) begin
        sl_hrdata = s_hrdata[i*DATA_W +: DATA_W];
        sl_hresp  = s_hresp[i];
        sl_hready = s_hready_resp[i];
      end
    m_hrdata = dflt ? '0 : sl_hrdata;
    m_hresp  = dflt ? d_hresp : sl_hresp;
    m_hready = dflt ? d_hready : sl_hready;
  end
  alb_mss_fab_ahbl_dflt_slv #(.AW(RGON_W + ADDR_W), .ERR_CNT_W(ERR_CNT_W)) u_dflt (
    .clk       (clk),
    .rst_a     (rst_a),
    .bus_clk_en(bus_clk_en),
    .accept    (m_hready),
    .miss      (!hit),
    .htrans    (m_htrans),
    .addr      ({m_hregion, m_haddr}),
    .err_clr   (err_clr),
    .hready    (d_hready),
    .hresp     (d_hresp),
    .err_cnt   (err_cnt),
    .err_addr  (err_addr)
  );
endmodule

// File: doc/alb_mss_fab_ahbl_rgon_mux.md
Name: alb_mss_fab_ahbl_rgon_mux

Overview:
- Multi-slave AHB-Lite decode/response-mux stage placed directly after the IBP-to-AHB-Lite converter in the MSS fabric.
- Decodes the IBP region field, carried as extra upper address bits, into one-hot HSEL for up to L_W slaves.
- Tracks the data-phase owner in a register and multiplexes HRDATA/HRESP/HREADY back to the master.
- Provides a built-in default slave that returns a two-cycle AHB ERROR for unmapped or disabled regions, and logs those errors.

Parameters:
- ADDR_W, 32, address width excluding region bits.
- DATA_W, 64, data width (32/64/128).
- RGON_W, 4, region field width.
- L_W, 4, number of slave ports (1..32, L_W <= 2**RGON_W).
- RGON_EN, {L_W{1'b1}}, per-slave enable mask; a disabled slot decodes to the default slave.
- ERR_CNT_W, 8, width of the saturating unmapped-access error counter.

Ports:
- clk  in  1  fabric clock.
- rst_a  in  1  asynchronous active-high reset.
- bus_clk_en  in  1  clock enable for N:1 ratios; all state updates only when 1.
- m_htrans  in  2  master HTRANS.
- m_hwrite  in  1  master HWRITE.
- m_haddr  in  ADDR_W  master HADDR.
- m_hregion  in  RGON_W  region (upper address) from converter.
- m_hsize  in  3  master HSIZE.
- m_hburst  in  3  master HBURST.
- m_hwdata  in  DATA_W  master HWDATA.
- m_hrdata  out  DATA_W  muxed read data.
- m_hresp  out  1  muxed response (0 OKAY, 1 ERROR).
- m_hready  out  1  muxed ready to master.
- s_hsel  out  L_W  one-hot slave select (address phase).
- s_htrans/s_hwrite/s_haddr/s_hsize/s_hburst/s_hwdata  out  as master  broadcast copies.
- s_hready  out  1  broadcast HREADY (equals m_hready).
- s_hrdata  in  L_W*DATA_W  slave read data, slave i at [i*DATA_W +: DATA_W].
- s_hresp  in  L_W  per-slave HRESP.
- s_hready_resp  in  L_W  per-slave HREADYOUT.
- err_cnt  out  ERR_CNT_W  saturating count of default-slave ERROR responses.
- err_addr  out  RGON_W+ADDR_W  {region,addr} of the most recent unmapped NSEQ/SEQ.
- err_clr  in  1  synchronous clear of err_cnt/err_addr (qualified by bus_clk_en).

Behaviour:
- Decode: hit = (m_hregion < L_W) && RGON_EN[m_hregion]. s_hsel[i] = hit && (m_hregion == i), combinational, regardless of HTRANS. Miss means the default slave owns the phase.
- Data-phase register dsel {idx, dflt}: loads on bus_clk_en && m_hready; holds otherwise. Reset: dflt=1, idx=0, default FSM in D_IDLE.
- Response mux:
  - dflt=0: m_hrdata/m_hresp/m_hready = slave idx values.
  - dflt=1: m_hrdata=0; hresp/hready from default FSM.
- Default FSM, advancing on bus_clk_en:
  - D_IDLE: output hready=1, hresp=0. Transition to D_ERR1 when the address phase accepted (m_hready=1) is a miss with HTRANS=NSEQ/SEQ.
  - D_ERR1: output hready=0, hresp=1. Next state D_ERR2.
  - D_ERR2: output hready=1, hresp=1. Next state D_ERR1 if the newly accepted phase is again a miss NSEQ/SEQ, else D_IDLE.
  - Miss with IDLE/BUSY: zero-wait OKAY, stay/return to D_IDLE.
- Error log: on entry to D_ERR1, err_cnt += 1 (saturate at all-ones) and err_addr captured. err_clr in the same cycle as an increment: clear wins, count becomes 0.
- Reset values: m_hready=1, m_hresp=0, m_hrdata=0, err_cnt=0, err_addr=0. Reset asserted mid-transfer aborts immediately to the reset state; no response is completed.
- Latency: zero added cycles on mapped paths (purely combinational address path, registered data-phase select). Unmapped NSEQ/SEQ costs exactly two data-phase cycles.
- bus_clk_en=0: all registers hold; outputs are stable functions of held state.
- Width rule: err_addr = {m_hregion, m_haddr}; idx width = max(1, clog2(L_W)).

Decomposition:
- Shared package alb_mss_fab_pkg: HTRANS encodings (IDLE/BUSY/NSEQ/SEQ), HRESP OKAY/ERROR, default-FSM state enum, clog2 helper.
- One sub-module: alb_mss_fab_ahbl_dflt_slv, containing the default-slave FSM and error counter/address log.

Test Plan:
- L_W=4, region=2 NSEQ read, slave2 returns 0xDEAD_BEEF_0123_4567 with hready_resp low 1 cycle → s_hsel=4'b0100; m_hready low 1 cycle; m_hrdata matches.
- Region=5 (unmapped) NSEQ write → m_hready 0 then 1, m_hresp 1 for both cycles; err_cnt=1; err_addr={4'h5,haddr}.
- RGON_EN=4'b1011, region=2 NSEQ → default-slave ERROR; s_hsel=0; slave2 sees no HSEL.
- Back-to-back: region 1 NSEQ followed by region 3 SEQ while slave1 stalls 2 cycles → dsel switches to 3 only after slave1 hready; data is not crossed.
- err_cnt saturation with ERR_CNT_W=2: 5 unmapped NSEQ → err_cnt=3; err_clr coincident with the 6th → err_cnt=0.
- bus_clk_en toggling 1:2 plus rst_a asserted during D_ERR1 → FSM returns to D_IDLE; m_hready=1, m_hresp=0 immediately.
